// File: rtl/wbu_if.sv
// Writeback unit bus bundle.
// Groups the ALU result handshake, the LSU load-response handshake, the load-issue
// notification, the pending-load bitmap and the register-file write port.
// With BLI_WBU_BYPASS_EN defined it also carries the two read-port bypass paths.
// Modports:
//   slave  - the writeback unit (consumes wbu_i_*, drives wbu_o_*)
//   master - the surrounding core / testbench (drives wbu_i_*, observes wbu_o_*)
interface wbu_if;
  logic        wbu_i_alu_valid;
  logic        wbu_o_alu_ready;
  logic [4:0]  wbu_i_alu_rd_addr;
  logic [31:0] wbu_i_alu_rd_data;
  logic        wbu_i_lsu_valid;
  logic        wbu_o_lsu_ready;
  logic [4:0]  wbu_i_lsu_rd_addr;
  logic [31:0] wbu_i_lsu_data;
  logic [2:0]  wbu_i_lsu_funct3;
  logic [1:0]  wbu_i_lsu_byte_off;
  logic        wbu_i_issue_valid;
  logic [4:0]  wbu_i_issue_rd_addr;
  logic [31:0] wbu_o_busy;
  logic        wbu_o_w_en;
  logic [4:0]  wbu_o_rd_addr;
  logic [31:0] wbu_o_rd_data;
  logic        wbu_o_err;
`ifdef BLI_WBU_BYPASS_EN
  logic [4:0]  wbu_i_rs1_addr;
  logic [4:0]  wbu_i_rs2_addr;
  logic [31:0] wbu_i_rs1_data;
  logic [31:0] wbu_i_rs2_data;
  logic [31:0] wbu_o_rs1_data;
  logic [31:0] wbu_o_rs2_data;
`endif

  modport slave (
    input  wbu_i_alu_valid, wbu_i_alu_rd_addr, wbu_i_alu_rd_data,
    input  wbu_i_lsu_valid, wbu_i_lsu_rd_addr, wbu_i_lsu_data,
    input  wbu_i_lsu_funct3, wbu_i_lsu_byte_off,
    input  wbu_i_issue_valid, wbu_i_issue_rd_addr,
`ifdef BLI_WBU_BYPASS_EN
    input  wbu_i_rs1_addr, wbu_i_rs2_addr, wbu_i_rs1_data, wbu_i_rs2_data,
    output wbu_o_rs1_data, wbu_o_rs2_data,
`endif
    output wbu_o_alu_ready, wbu_o_lsu_ready, wbu_o_busy,
    output wbu_o_w_en, wbu_o_rd_addr, wbu_o_rd_data, wbu_o_err
  );

  modport master (
    output wbu_i_alu_valid, wbu_i_alu_rd_addr, wbu_i_alu_rd_data,
    output wbu_i_lsu_valid, wbu_i_lsu_rd_addr, wbu_i_lsu_data,
    output wbu_i_lsu_funct3, wbu_i_lsu_byte_off,
    output wbu_i_issue_valid, wbu_i_issue_rd_addr,
`ifdef BLI_WBU_BYPASS_EN
    output wbu_i_rs1_addr, wbu_i_rs2_addr, wbu_i_rs1_data, wbu_i_rs2_data,
    input  wbu_o_rs1_data, wbu_o_rs2_data,
`endif
    input  wbu_o_alu_ready, wbu_o_lsu_ready, wbu_o_busy,
    input  wbu_o_w_en, wbu_o_rd_addr, wbu_o_rd_data, wbu_o_err
  );
endinterface

// File: rtl/wbu.sv
// Writeback unit of the BLI201V32I core.
// Arbitrates ALU results and load responses (LSU has fixed priority), formats load
// data by funct3/byte offset, and drives the register-file write port from a
// registered stage (one write per cycle). Keeps a pending-load scoreboard for the IDU.
// Ports:
//   clk  - core clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - wbu_if.slave: ALU/LSU handshakes, load issue, busy bitmap, write port, err
// Optional feature: define BLI_WBU_BYPASS_EN to add combinational rs1/rs2 bypass from
// the registered write stage.
module wbu #(
  parameter int unsigned XLEN = 32
) (
  input logic   clk,
  input logic   rst,
  wbu_if.slave  bus
);

  logic            lsu_acc, alu_acc;
  logic            ld_illegal;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_data;

  logic            w_en_q, w_en_d;
  logic [4:0]      rd_addr_q, rd_addr_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic [31:0]     busy_q, busy_d;
  logic            err_q, err_d;

  // LSU always wins; ALU is only accepted when no load response is offered.
  assign lsu_acc = bus.wbu_i_lsu_valid;
  assign alu_acc = bus.wbu_i_alu_valid & ~bus.wbu_i_lsu_valid;

  assign bus.wbu_o_lsu_ready = 1'b1;
  assign bus.wbu_o_alu_ready = ~bus.wbu_i_lsu_valid;

  // Load formatting
  always_comb begin
    ld_byte    = bus.wbu_i_lsu_data[{bus.wbu_i_lsu_byte_off, 3'b000} +: 8];
    ld_half    = bus.wbu_i_lsu_byte_off[1] ? bus.wbu_i_lsu_data[31:16]
                                           : bus.wbu_i_lsu_data[15:0];
    ld_data    = '0;
    ld_illegal = 1'b0;
    case (bus.wbu_i_lsu_funct3)
      3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
      3'b010:  ld_data = bus.wbu_i_lsu_data;
      default: ld_illegal = 1'b1;
    endcase
  end

  // Next state: output stage, error pulse and scoreboard
  always_comb begin
    w_en_d    = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    err_d     = 1'b0;
    busy_d    = busy_q;
    if (lsu_acc) begin
      w_en_d    = (bus.wbu_i_lsu_rd_addr != 5'd0);
      rd_addr_d = bus.wbu_i_lsu_rd_addr;
      rd_data_d = ld_data;
      err_d     = ld_illegal;
      busy_d[bus.wbu_i_lsu_rd_addr] = 1'b0;
    end else if (alu_acc) begin
      w_en_d    = (bus.wbu_i_alu_rd_addr != 5'd0);
      rd_addr_d = bus.wbu_i_alu_rd_addr;
      rd_data_d = bus.wbu_i_alu_rd_data;
    end
    // Applied after the clear so a same-index issue keeps the bit set.
    if (bus.wbu_i_issue_valid && bus.wbu_i_issue_rd_addr != 5'd0) begin
      busy_d[bus.wbu_i_issue_rd_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_en_q    <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      busy_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      w_en_q    <= w_en_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign bus.wbu_o_w_en    = w_en_q;
  assign bus.wbu_o_rd_addr = rd_addr_q;
  assign bus.wbu_o_rd_data = rd_data_q;
  assign bus.wbu_o_busy    = busy_q;
  assign bus.wbu_o_err     = err_q;

`ifdef BLI_WBU_BYPASS_EN
  // Forward the write being presented this cycle; x0 is never forwarded.
  always_comb begin
    bus.wbu_o_rs1_data = bus.wbu_i_rs1_data;
    bus.wbu_o_rs2_data = bus.wbu_i_rs2_data;
    if (w_en_q && rd_addr_q == bus.wbu_i_rs1_addr && bus.wbu_i_rs1_addr != 5'd0) begin
      bus.wbu_o_rs1_data = rd_data_q;
    end
    if (w_en_q && rd_addr_q == bus.wbu_i_rs2_addr && bus.wbu_i_rs2_addr != 5'd0) begin
      bus.wbu_o_rs2_data = rd_data_q;
    end
  end
`endif

endmodule

// File: tb/tb_wbu.sv
// Randomized self-checking bench for wbu against a behavioural model of the
// writeback rules (priority, load formatting, x0 suppression, scoreboard).
module tb_wbu;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  wbu_if bus ();

  wbu u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Model state: what the write port should show now.
  logic        m_wen, m_err;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          m_busy [32];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Load result straight from the ISA definition, using integer arithmetic.
  function automatic logic [31:0] load_value(input logic [31:0] word, input logic [2:0] f3,
                                             input logic [1:0] off);
    longint w = longint'(word);
    longint b = (w >> (8 * int'(off))) & 255;
    longint h = (w >> (16 * int'(off[1]))) & 65535;
    case (f3)
      3'd0:    return (b >= 128) ? 32'(b - 256) : 32'(b);
      3'd4:    return 32'(b);
      3'd1:    return (h >= 32768) ? 32'(h - 65536) : 32'(h);
      3'd5:    return 32'(h);
      3'd2:    return word;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] busy_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  // One clock: predict from the current inputs, clock, then compare.
  task automatic step();
    logic        n_wen, n_err;
    logic [4:0]  n_addr;
    logic [31:0] n_data;
    bit          n_busy [32];
    #1;
    check_eq("alu_ready", 32'(bus.wbu_o_alu_ready), 32'(!bus.wbu_i_lsu_valid));
    check_eq("lsu_ready", 32'(bus.wbu_o_lsu_ready), 32'd1);
    n_busy = m_busy;
    if (rst) begin
      n_wen = 0; n_err = 0; n_addr = 0; n_data = 0;
      for (int i = 0; i < 32; i++) n_busy[i] = 0;
    end else begin
      n_wen = 0; n_err = 0; n_addr = m_addr; n_data = m_data;
      if (bus.wbu_i_lsu_valid) begin
        n_addr = bus.wbu_i_lsu_rd_addr;
        n_data = load_value(bus.wbu_i_lsu_data, bus.wbu_i_lsu_funct3, bus.wbu_i_lsu_byte_off);
        n_wen  = (n_addr != 0);
        n_err  = bus.wbu_i_lsu_funct3 inside {3'd3, 3'd6, 3'd7};
        n_busy[n_addr] = 0;
      end else if (bus.wbu_i_alu_valid) begin
        n_addr = bus.wbu_i_alu_rd_addr;
        n_data = bus.wbu_i_alu_rd_data;
        n_wen  = (n_addr != 0);
      end
      if (bus.wbu_i_issue_valid && bus.wbu_i_issue_rd_addr != 0)
        n_busy[bus.wbu_i_issue_rd_addr] = 1;
    end
    @(posedge clk);
    #1;
    m_wen = n_wen; m_err = n_err; m_addr = n_addr; m_data = n_data; m_busy = n_busy;
    check_eq("w_en", 32'(bus.wbu_o_w_en), 32'(m_wen));
    check_eq("err", 32'(bus.wbu_o_err), 32'(m_err));
    check_eq("busy", bus.wbu_o_busy, busy_vec());
    if (m_wen) begin
      check_eq("rd_addr", 32'(bus.wbu_o_rd_addr), 32'(m_addr));
      check_eq("rd_data", bus.wbu_o_rd_data, m_data);
    end
`ifdef BLI_WBU_BYPASS_EN
    check_eq("rs1_byp", bus.wbu_o_rs1_data,
             (m_wen && m_addr == bus.wbu_i_rs1_addr && bus.wbu_i_rs1_addr != 0)
             ? m_data : bus.wbu_i_rs1_data);
    check_eq("rs2_byp", bus.wbu_o_rs2_data,
             (m_wen && m_addr == bus.wbu_i_rs2_addr && bus.wbu_i_rs2_addr != 0)
             ? m_data : bus.wbu_i_rs2_data);
`endif
  endtask

  task automatic idle();
    bus.wbu_i_alu_valid   = 0;
    bus.wbu_i_lsu_valid   = 0;
    bus.wbu_i_issue_valid = 0;
  endtask

  task automatic drive_load(input logic [4:0] rd, input logic [31:0] word, input logic [2:0] f3,
                            input logic [1:0] off);
    bus.wbu_i_lsu_valid    = 1;
    bus.wbu_i_lsu_rd_addr  = rd;
    bus.wbu_i_lsu_data     = word;
    bus.wbu_i_lsu_funct3   = f3;
    bus.wbu_i_lsu_byte_off = off;
  endtask

  typedef struct {logic [2:0] f3; logic [1:0] off; logic [31:0] exp;} ld_vec_t;
  ld_vec_t vecs [6] = '{'{3'd0, 2'd3, 32'hFFFFFF80}, '{3'd4, 2'd3, 32'h00000080},
                        '{3'd1, 2'd2, 32'hFFFF80FF}, '{3'd5, 2'd3, 32'h000080FF},
                        '{3'd2, 2'd1, 32'h80FF7F01}, '{3'd3, 2'd0, 32'h00000000}};

  initial begin
    bit alu_pending;
    rst = 1;
    idle();
    bus.wbu_i_alu_rd_addr = 0; bus.wbu_i_alu_rd_data = 0;
    drive_load(0, 0, 0, 0);
    bus.wbu_i_lsu_valid = 0;
    bus.wbu_i_issue_rd_addr = 0;
`ifdef BLI_WBU_BYPASS_EN
    bus.wbu_i_rs1_addr = 0; bus.wbu_i_rs2_addr = 0;
    bus.wbu_i_rs1_data = 0; bus.wbu_i_rs2_data = 32'hA5A5A5A5;
`endif
    step(); step();
    check_eq("rst_rd_data", bus.wbu_o_rd_data, 32'd0);
    check_eq("rst_rd_addr", 32'(bus.wbu_o_rd_addr), 32'd0);
    rst = 0;

    // ALU alone
    bus.wbu_i_alu_valid = 1; bus.wbu_i_alu_rd_addr = 5; bus.wbu_i_alu_rd_data = 32'hDEADBEEF;
    step();
    check_eq("alu_data", bus.wbu_o_rd_data, 32'hDEADBEEF);
    idle(); step();
    check_eq("alu_w_en_drop", 32'(bus.wbu_o_w_en), 32'd0);

    // Load formatting table
    foreach (vecs[i]) begin
      drive_load(7, 32'h80FF7F01, vecs[i].f3, vecs[i].off);
      step();
      check_eq("fmt_vec", bus.wbu_o_rd_data, vecs[i].exp);
    end
    idle(); step();

    // Contention: LSU first, ALU next
    bus.wbu_i_alu_valid = 1; bus.wbu_i_alu_rd_addr = 12; bus.wbu_i_alu_rd_data = 32'h11112222;
    drive_load(13, 32'h33334444, 3'd2, 0);
    step();
    bus.wbu_i_lsu_valid = 0; step();
    check_eq("contend_alu", bus.wbu_o_rd_data, 32'h11112222);
    idle(); step();

    // Scoreboard: set, clear, same-cycle set wins, rd 0 ignored
    bus.wbu_i_issue_valid = 1; bus.wbu_i_issue_rd_addr = 9; step();
    idle(); drive_load(9, 32'h1, 3'd2, 0); step();
    idle(); bus.wbu_i_issue_valid = 1; bus.wbu_i_issue_rd_addr = 9; step();
    drive_load(9, 32'h2, 3'd2, 0); step();
    check_eq("sb_set_wins", 32'(bus.wbu_o_busy[9]), 32'd1);
    idle(); bus.wbu_i_issue_valid = 1; bus.wbu_i_issue_rd_addr = 0; step();
    idle(); bus.wbu_i_alu_valid = 1; bus.wbu_i_alu_rd_addr = 0; step();

    // Reset while a write is pending
    bus.wbu_i_alu_rd_addr = 5; step();
    rst = 1; idle(); step();
    rst = 0;

    // Randomized traffic; an unaccepted ALU offer is held stable until taken
    alu_pending = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (!alu_pending) begin
        bus.wbu_i_alu_valid   = $urandom_range(0, 1);
        bus.wbu_i_alu_rd_addr = 5'($urandom_range(0, 31));
        bus.wbu_i_alu_rd_data = $urandom;
      end
      bus.wbu_i_lsu_valid = ($urandom_range(0, 2) == 0);
      bus.wbu_i_lsu_rd_addr = 5'($urandom_range(0, 15));
      bus.wbu_i_lsu_data = $urandom;
      bus.wbu_i_lsu_funct3 = 3'($urandom_range(0, 7));
      bus.wbu_i_lsu_byte_off = 2'($urandom_range(0, 3));
      bus.wbu_i_issue_valid = $urandom_range(0, 1);
      bus.wbu_i_issue_rd_addr = 5'($urandom_range(0, 15));
`ifdef BLI_WBU_BYPASS_EN
      bus.wbu_i_rs1_addr = 5'($urandom_range(0, 7));
      bus.wbu_i_rs2_addr = 5'($urandom_range(0, 7));
      bus.wbu_i_rs1_data = $urandom;
      bus.wbu_i_rs2_data = $urandom;
`endif
      alu_pending = bus.wbu_i_alu_valid && bus.wbu_i_lsu_valid && !rst;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
